// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes, funct codes,
// ALU control codes, ALUOp selectors and the per-state Moore control word.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    aluop_e     aluop;
  } ctrl_t;

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) || (f == F_SLT);
  endfunction

  // Write enables here are raw; the top gates them with en and reset.
  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    c.aluop = ALUOP_ADD;
    case (s)
      S_FETCH: begin
        c.alusrcb = 2'b01;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      S_DECODE: c.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-path bundle: instruction fields and flags in, datapath selects/strobes and status out.
interface multicycle_control_if;
  logic        en;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        pcen;
  logic        iord;
  logic        memwrite;
  logic        irwrite;
  logic        regdst;
  logic        memtoreg;
  logic        regwrite;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic [1:0]  pcsrc;
  logic [2:0]  alucontrol;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] retired;

  modport master (
    output en, op, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
    input  alusrca, alusrcb, pcsrc, alucontrol, state, illegal, retired
  );

  modport slave (
    input  en, op, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
    output alusrca, alusrcb, pcsrc, alucontrol, state, illegal, retired
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU control: ALUOp picks add/sub directly or defers to the R-type funct field.
module alu_decoder
  import mc_pkg::*;
(
  input  aluop_e     aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          F_SUB:   alucontrol_o = ALU_SUB;
          F_AND:   alucontrol_o = ALU_AND;
          F_OR:    alucontrol_o = ALU_OR;
          F_SLT:   alucontrol_o = ALU_SLT;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with registered Moore control word, sticky illegal flag and
// retired-instruction counter; everything advances only on en steps.
module multicycle_control
  import mc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  multicycle_control_if.slave bus
);

  state_e      state_q, state_d;
  ctrl_t       ctrl_q;
  logic        illegal_q, illegal_d;
  logic [31:0] retired_q, retired_d;
  logic        go;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_ok(bus.funct)) begin
              state_d = S_EXEC;
            end else begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        state_d   = S_FETCH;
        retired_d = retired_q + 32'd1;
      end
      default:  state_d = S_FETCH;
    endcase
  end

  // ctrl_q tracks state_q so the selects come straight from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      ctrl_q    <= state_ctrl(S_FETCH);
      illegal_q <= 1'b0;
      retired_q <= 32'd0;
    end else if (bus.en) begin
      state_q   <= state_d;
      ctrl_q    <= state_ctrl(state_d);
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Strobes are also held off while reset is asserted, even though the state shows FETCH.
  assign go = bus.en & reset;

  assign bus.pcen     = (ctrl_q.pcwrite | (ctrl_q.branch & bus.zero)) & go;
  assign bus.memwrite = ctrl_q.memwrite & go;
  assign bus.irwrite  = ctrl_q.irwrite & go;
  assign bus.regwrite = ctrl_q.regwrite & go;
  assign bus.iord     = ctrl_q.iord;
  assign bus.regdst   = ctrl_q.regdst;
  assign bus.memtoreg = ctrl_q.memtoreg;
  assign bus.alusrca  = ctrl_q.alusrca;
  assign bus.alusrcb  = ctrl_q.alusrcb;
  assign bus.pcsrc    = ctrl_q.pcsrc;
  assign bus.state    = state_q;
  assign bus.illegal  = illegal_q;
  assign bus.retired  = retired_q;

  alu_decoder u_alu_dec (
    .aluop_i      (ctrl_q.aluop),
    .funct_i      (bus.funct),
    .alucontrol_o (bus.alucontrol)
  );

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 en  in  1  step enable (divided-clock tick or single-step); state, counter and write strobes act only when en=1.
REQ-004 op  in  6  opcode field of the instruction register.
REQ-005 funct  in  6  funct field of the instruction register.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 pcen  out  1  PC write: (pcwrite | (branch & zero)) & en.
REQ-008 iord  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-009 memwrite  out  1  data memory write strobe, gated by en.
REQ-010 irwrite  out  1  instruction register load, gated by en.
REQ-011 regdst  out  1  write register select: 1=rd, 0=rt.
REQ-012 memtoreg  out  1  writeback data select: 1=MDR, 0=ALUOut.
REQ-013 regwrite  out  1  register file write strobe, gated by en.
REQ-014 alusrca  out  1  ALU A select: 0=PC, 1=rs.
REQ-015 alusrcb  out  2  ALU B select: 00=rt, 01=4, 10=signext imm, 11=signext imm<<2.
REQ-016 pcsrc  out  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target.
REQ-017 alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-018 state  out  4  current state encoding, for the seven-segment display.
REQ-019 illegal  out  1  sticky flag: unsupported op/funct decoded.
REQ-020 retired  out  32  count of completed instructions.

Function
REQ-021 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP; Moore outputs decoded from the registered state.
REQ-022 FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, irwrite=1, pcwrite=1; next DECODE.
REQ-023 DECODE: alusrca=0, alusrcb=11, alucontrol=010; next by op: 100011/101011->MEMADR, 000000->EXEC, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP.
REQ-024 MEMADR: alusrca=1, alusrcb=10, add; lw->MEMRD, sw->MEMWR. MEMRD: iord=1 ->MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1 ->FETCH. MEMWR: iord=1, memwrite=1 ->FETCH.
REQ-025 EXEC: alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt) ->ALUWB. ALUWB: regdst=1, memtoreg=0, regwrite=1 ->FETCH.
REQ-026 BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1 ->FETCH. ADDIEX: alusrca=1, alusrcb=10, add ->ADDIWB: regdst=0, regwrite=1 ->FETCH. JUMP: pcsrc=10, pcwrite=1 ->FETCH.
REQ-027 Unlisted outputs are 0 in every state (alucontrol defaults 010, alusrcb 00).
REQ-028 Unsupported op in DECODE, or op=000000 with unlisted funct: illegal set to 1, next FETCH, no writes, retired unchanged.
REQ-029 Instruction latency in en-steps: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-030 retired increments by 1 on each en-qualified transition to FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP; wraps 0xFFFFFFFF->0.
REQ-031 en=0: state, illegal and retired hold; all write strobes (pcen, irwrite, memwrite, regwrite) 0; select outputs still reflect state.

Reset
REQ-032 reset=0 forces asynchronously state=FETCH, illegal=0, retired=0; outputs then show FETCH decode with strobes gated by en.
REQ-033 Reset mid-instruction abandons it; no strobe asserts while reset=0; retired not incremented.

Structure
REQ-034 Shared package mc_pkg holds state encodings, opcode and funct constants, alucontrol codes and ALUOp codes.
REQ-035 One combinational sub-module alu_decoder maps ALUOp(2)+funct(6) to alucontrol(3); FSM and counter in multicycle_control.

Verification
REQ-036 Reset low, en=1, then release; op=100011 held -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; regwrite=1 only in MEMWB; retired=1.
REQ-037 op=000000, funct=100010 -> EXEC drives alucontrol=110; ALUWB regdst=1, regwrite=1; 4 steps; retired increments.
REQ-038 op=000100 with zero=1 in BRANCH -> pcen=1, pcsrc=01; with zero=0 -> pcen=0; both 3 steps.
REQ-039 op=111111 -> DECODE->FETCH, illegal=1 stays 1 across following lw; retired unchanged for the bad instruction.
REQ-040 en toggled 1,0,0,1 during sw -> state holds while en=0, memwrite=0 while en=0, sw completes after 4 en-steps; reset pulled low in MEMADR -> immediate FETCH, retired unchanged.
